// File: rtl/avalon_packetizer_if.sv
// Avalon-ST message interface: one data word per beat with sop/eop framing and
// an empty count giving the number of unused low-order bytes on the eop word.
interface avalon_st_if #(
   parameter int DATA_WIDTH_IN_BYTES = 4
);
   localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

   logic                             valid;
   logic                             rdy;
   logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
   logic                             sop;
   logic                             eop;
   logic [EMPTY_W-1:0]               empty;

   modport master (output valid, data, sop, eop, empty, input rdy);
   modport slave  (input valid, data, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_packetizer.sv
// Frames an unframed word stream into Avalon-ST messages from byte-length commands.
// Define AVALON_PACKETIZER_ZERO_PAD_EN to force the unused bytes of the eop word to zero.
module avalon_packetizer #(
   parameter int DATA_WIDTH_IN_BYTES = 4,
   parameter int LEN_WIDTH           = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_valid,
   output logic                             cmd_rdy,
   input  logic [LEN_WIDTH-1:0]             cmd_len,
   input  logic                             data_in_valid,
   output logic                             data_in_rdy,
   input  logic [DATA_WIDTH_IN_BYTES*8-1:0] data_in,
   avalon_st_if.master                      msg_out,
   output logic                             zero_len_indi,
   output logic                             msg_done_indi
);
   localparam int W       = DATA_WIDTH_IN_BYTES;
   localparam int DW      = W * 8;
   localparam int EMPTY_W = (W > 1) ? $clog2(W) : 1;
   localparam logic [LEN_WIDTH:0] W_EXT    = (LEN_WIDTH + 1)'(W);
   localparam logic [LEN_WIDTH:0] W_EXT_M1 = (LEN_WIDTH + 1)'(W - 1);

   typedef enum logic {IDLE, IN_MSG} state_t;

`ifdef AVALON_PACKETIZER_ZERO_PAD_EN
   function automatic logic [DW-1:0] pad_zero(input logic [DW-1:0] d, input logic [EMPTY_W-1:0] e);
      logic [DW-1:0] r;
      r = d;
      for (int i = 0; i < W; i++) begin
         if (i < int'(e)) r[i*8 +: 8] = 8'h00;
      end
      return r;
   endfunction
`endif

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] words_left_q, words_left_d;
   logic [EMPTY_W-1:0]   last_empty_q, last_empty_d;
   logic                 first_q, first_d;
   logic                 out_valid_q, out_valid_d;
   logic [DW-1:0]        out_data_q, out_data_d;
   logic                 out_sop_q, out_sop_d;
   logic                 out_eop_q, out_eop_d;
   logic [EMPTY_W-1:0]   out_empty_q, out_empty_d;
   logic                 zero_len_q, zero_len_d;
   logic                 msg_done_q, msg_done_d;

   logic                 cmd_fire, data_fire, out_fire, last_word;
   logic [LEN_WIDTH:0]   len_ext, rem_ext;
   logic [DW-1:0]        load_data;

   assign cmd_rdy     = (state_q == IDLE);
   assign data_in_rdy = (state_q == IN_MSG) & (~out_valid_q | msg_out.rdy);
   assign cmd_fire    = cmd_valid & cmd_rdy;
   assign data_fire   = data_in_valid & data_in_rdy;
   assign out_fire    = out_valid_q & msg_out.rdy;
   assign last_word   = (words_left_q == LEN_WIDTH'(1));

   // One extra bit keeps the round-up add from wrapping at the maximum length.
   assign len_ext = {1'b0, cmd_len};
   assign rem_ext = len_ext % W_EXT;

`ifdef AVALON_PACKETIZER_ZERO_PAD_EN
   assign load_data = last_word ? pad_zero(data_in, last_empty_q) : data_in;
`else
   assign load_data = data_in;
`endif

   always_comb begin
      state_d      = state_q;
      words_left_d = words_left_q;
      last_empty_d = last_empty_q;
      first_d      = first_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sop_d    = out_sop_q;
      out_eop_d    = out_eop_q;
      out_empty_d  = out_empty_q;
      zero_len_d   = cmd_fire & (cmd_len == '0);
      msg_done_d   = out_fire & out_eop_q;

      case (state_q)
         IDLE: begin
            if (cmd_fire && (cmd_len != '0)) begin
               words_left_d = LEN_WIDTH'((len_ext + W_EXT_M1) / W_EXT);
               last_empty_d = EMPTY_W'((W_EXT - rem_ext) % W_EXT);
               first_d      = 1'b1;
               state_d      = IN_MSG;
            end
         end
         IN_MSG: begin
            if (data_fire) begin
               first_d      = 1'b0;
               words_left_d = words_left_q - LEN_WIDTH'(1);
               if (last_word) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A new load takes priority over clearing a register that drains this cycle.
      if (data_fire) begin
         out_valid_d = 1'b1;
         out_data_d  = load_data;
         out_sop_d   = first_q;
         out_eop_d   = last_word;
         out_empty_d = last_word ? last_empty_q : '0;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_sop_d   = 1'b0;
         out_eop_d   = 1'b0;
         out_empty_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         words_left_q <= '0;
         last_empty_q <= '0;
         first_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
         out_empty_q  <= '0;
         zero_len_q   <= 1'b0;
         msg_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         words_left_q <= words_left_d;
         last_empty_q <= last_empty_d;
         first_q      <= first_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sop_q    <= out_sop_d;
         out_eop_q    <= out_eop_d;
         out_empty_q  <= out_empty_d;
         zero_len_q   <= zero_len_d;
         msg_done_q   <= msg_done_d;
      end
   end

   assign msg_out.valid = out_valid_q;
   assign msg_out.data  = out_data_q;
   assign msg_out.sop   = out_sop_q;
   assign msg_out.eop   = out_eop_q;
   assign msg_out.empty = out_empty_q;
   assign zero_len_indi = zero_len_q;
   assign msg_done_indi = msg_done_q;
endmodule

// File: tb/tb_avalon_packetizer.sv
// Scoreboard bench for avalon_packetizer (W=4): directed messages push expected beats,
// a negedge monitor pops and compares every output handshake.
module tb_avalon_packetizer;
   typedef struct packed {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_rdy;
   logic [15:0] cmd_len;
   logic        data_in_valid;
   logic        data_in_rdy;
   logic [31:0] data_in;
   logic        zero_len_indi;
   logic        msg_done_indi;

   int vectors     = 0;
   int miscompares = 0;
   int done_count  = 0;
   int zero_count  = 0;
   beat_t exp_q[$];

   avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) msg_if ();

   avalon_packetizer #(.DATA_WIDTH_IN_BYTES(4), .LEN_WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_rdy       (cmd_rdy),
      .cmd_len       (cmd_len),
      .data_in_valid (data_in_valid),
      .data_in_rdy   (data_in_rdy),
      .data_in       (data_in),
      .msg_out       (msg_if),
      .zero_len_indi (zero_len_indi),
      .msg_done_indi (msg_done_indi)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic send_cmd(input logic [15:0] len);
      bit ok = 0;
      cmd_valid = 1'b1;
      cmd_len   = len;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_rdy) begin ok = 1; break; end
      end
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL cmd_timeout: cmd_rdy=%0b, expected 1", cmd_rdy);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic [31:0] exp_d,
                            input logic s, input logic e, input logic [1:0] emp);
      bit ok = 0;
      exp_q.push_back('{data: exp_d, sop: s, eop: e, empty: emp});
      data_in_valid = 1'b1;
      data_in       = w;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (data_in_rdy) begin ok = 1; break; end
      end
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL data_timeout: data_in_rdy=%0b, expected 1", data_in_rdy);
      end
      @(posedge clk); #1;
      data_in_valid = 1'b0;
   endtask

   // Monitor: scoreboard pops, hold-stability under backpressure, msg_done timing.
   logic        prev_stall = 1'b0;
   logic        prev_eop_fire = 1'b0;
   logic [31:0] prev_data;
   logic [3:0]  prev_flags;
   always @(negedge clk) begin
      beat_t b;
      if (prev_eop_fire || msg_done_indi)
         chk("msg_done_timing", 32'(msg_done_indi), 32'(prev_eop_fire));
      if (msg_done_indi) done_count++;
      if (zero_len_indi) zero_count++;
      if (prev_stall) begin
         chk("hold_valid", 32'(msg_if.valid), 32'd1);
         chk("hold_data", msg_if.data, prev_data);
         chk("hold_flags", 32'({msg_if.sop, msg_if.eop, msg_if.empty}), 32'(prev_flags));
      end
      if (msg_if.valid && !msg_if.rdy)
         chk("bp_data_in_rdy", 32'(data_in_rdy), 32'd0);
      if (msg_if.valid && msg_if.rdy) begin
         if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_beat: got data 0x%08h sop=%0b eop=%0b, expected no beat",
                     msg_if.data, msg_if.sop, msg_if.eop);
         end else begin
            b = exp_q.pop_front();
            chk("beat_data", msg_if.data, b.data);
            chk("beat_flags", 32'({msg_if.sop, msg_if.eop, msg_if.empty}),
                32'({b.sop, b.eop, b.empty}));
         end
      end
      prev_stall    = msg_if.valid & ~msg_if.rdy & ~rst;
      prev_eop_fire = msg_if.valid & msg_if.rdy & msg_if.eop & ~rst;
      prev_data     = msg_if.data;
      prev_flags    = {msg_if.sop, msg_if.eop, msg_if.empty};
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] pad5, pad3, pad7;
`ifdef AVALON_PACKETIZER_ZERO_PAD_EN
      pad5 = 32'hAA000000; pad3 = 32'hDEADBE00; pad7 = 32'h05060700;
`else
      pad5 = 32'hAABBCCDD; pad3 = 32'hDEADBEEF; pad7 = 32'h05060708;
`endif
      rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0;
      data_in_valid = 1'b0; data_in = '0; msg_if.rdy = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(msg_if.valid), 32'd0);
      chk("rst_data", msg_if.data, 32'd0);
      chk("rst_flags", 32'({msg_if.sop, msg_if.eop, msg_if.empty}), 32'd0);
      chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
      chk("rst_data_in_rdy", 32'(data_in_rdy), 32'd0);
      chk("rst_indis", 32'({zero_len_indi, msg_done_indi}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Two full words
      send_cmd(16'd8);
      send_word(32'h01020304, 32'h01020304, 1'b1, 1'b0, 2'd0);
      send_word(32'h05060708, 32'h05060708, 1'b0, 1'b1, 2'd0);
      repeat (3) @(posedge clk); #1;

      // Partial last word
      send_cmd(16'd5);
      send_word(32'h11223344, 32'h11223344, 1'b1, 1'b0, 2'd0);
      send_word(32'hAABBCCDD, pad5, 1'b0, 1'b1, 2'd3);
      repeat (3) @(posedge clk); #1;

      // Single word, then command path reopens immediately
      send_cmd(16'd3);
      send_word(32'hDEADBEEF, pad3, 1'b1, 1'b1, 2'd1);
      @(negedge clk);
      chk("single_cmd_rdy", 32'(cmd_rdy), 32'd1);
      repeat (3) @(posedge clk); #1;

      // Backpressure: first beat held three cycles
      msg_if.rdy = 1'b0;
      send_cmd(16'd12);
      send_word(32'hA0A1A2A3, 32'hA0A1A2A3, 1'b1, 1'b0, 2'd0);
      fork
         begin
            send_word(32'hB0B1B2B3, 32'hB0B1B2B3, 1'b0, 1'b0, 2'd0);
            send_word(32'hC0C1C2C3, 32'hC0C1C2C3, 1'b0, 1'b1, 2'd0);
         end
         begin
            repeat (3) @(posedge clk); #1;
            msg_if.rdy = 1'b1;
         end
      join
      repeat (3) @(posedge clk); #1;

      // Zero length, then a one-word message
      send_cmd(16'd0);
      @(negedge clk);
      chk("zero_len_pulse", 32'(zero_len_indi), 32'd1);
      chk("zero_len_no_beat", 32'(msg_if.valid), 32'd0);
      chk("zero_len_cmd_rdy", 32'(cmd_rdy), 32'd1);
      @(negedge clk);
      chk("zero_len_clear", 32'(zero_len_indi), 32'd0);
      @(posedge clk); #1;
      send_cmd(16'd4);
      send_word(32'h12345678, 32'h12345678, 1'b1, 1'b1, 2'd0);
      repeat (3) @(posedge clk); #1;

      // Reset after 1 of 3 words
      send_cmd(16'd12);
      send_word(32'h0F0E0D0C, 32'h0F0E0D0C, 1'b1, 1'b0, 2'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_valid", 32'(msg_if.valid), 32'd0);
      chk("midrst_cmd_rdy", 32'(cmd_rdy), 32'd1);
      chk("midrst_data_in_rdy", 32'(data_in_rdy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      send_cmd(16'd4);
      send_word(32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1, 2'd0);
      repeat (3) @(posedge clk); #1;

      // Seven bytes: one pad byte on the last word
      send_cmd(16'd7);
      send_word(32'h01020304, 32'h01020304, 1'b1, 1'b0, 2'd0);
      send_word(32'h05060708, pad7, 1'b0, 1'b1, 2'd1);
      repeat (5) @(posedge clk);
      @(negedge clk);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("msg_done_count", 32'(done_count), 32'd7);
      chk("zero_len_count", 32'(zero_count), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/avalon_packetizer.md
# avalon_packetizer

Transmit-side framer for the team's Avalon-ST message path. Takes an unframed word stream and a per-message byte-length command, and emits well-framed messages on an `avalon_st_if` master: sop on the first word, eop on the last, correct `empty`, and zeroed pad bytes. Its output always passes `avalon_enforcer` checks with no `missing_sop_indi` or `unexpected_sop_indi`. It sits upstream of any block that consumes enforced messages.

## Interface
- `DATA_WIDTH_IN_BYTES`, 4: bytes per data word (W); at least 1.
- `LEN_WIDTH`, 16: width of the message byte-length field.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  length command valid.
- `cmd_rdy`  out  1  length command accepted when `cmd_valid & cmd_rdy`.
- `cmd_len`  in  LEN_WIDTH  message length in bytes.
- `data_in_valid`  in  1  payload word valid.
- `data_in_rdy`  out  1  payload word accepted when `data_in_valid & data_in_rdy`.
- `data_in`  in  W*8  payload word; first byte in the MSB.
- `msg_out`  `avalon_st_if.master`  —  signals `valid`, `rdy`, `data`[W*8], `sop`, `eop`, `empty`[log2up(W)].
- `zero_len_indi`  out  1  one-cycle pulse when a command with `cmd_len==0` is accepted.
- `msg_done_indi`  out  1  one-cycle pulse when an eop word handshakes on `msg_out`.

## Operation
- **States.** `IDLE` and `IN_MSG`.
- **IDLE.**
  - `cmd_rdy=1`, `data_in_rdy=0`.
  - On command accept with `cmd_len>0`:
    - `words_left = ceil(cmd_len/W)`
    - `last_empty = (W - cmd_len mod W) mod W`
    - `first = 1`
    - go to `IN_MSG`.
  - On command accept with `cmd_len==0`: pulse `zero_len_indi`, stay in `IDLE`, emit nothing.
- **IN_MSG.**
  - `cmd_rdy=0`.
  - `data_in_rdy = ~msg_out.valid | msg_out.rdy` (output register free, or draining this cycle).
  - On each accepted word:
    - Load the output register: `valid=1`, `data=data_in`, `sop=first`, `eop=(words_left==1)`, `empty = eop ? last_empty : 0`.
    - Clear `first` and decrement `words_left`.
    - When `words_left==1`, return to `IDLE`.
- **Output register.** Cleared when it handshakes (`valid & rdy`) and no new word loads in the same cycle.
- **Pad bytes.** On the eop word, the low `empty` bytes, `data[empty*8-1:0]`, are forced to 0 (see Configuration).
- **Arithmetic.**
  - `words_left` is LEN_WIDTH bits.
  - `ceil` is computed as `(cmd_len + W - 1) / W`, using LEN_WIDTH+1 bit intermediates; no overflow at `cmd_len = 2^LEN_WIDTH - 1`.
  - `empty` is never nonzero on a non-eop word.
- **Single-word message.** `sop` and `eop` are both set on the same word.
- **Reset.** Any partial message is dropped; no eop is emitted for it. The next message starts with `sop`.

## Timing
- **Reset values:**
  - state `IDLE`
  - `msg_out.valid/sop/eop` = 0, `msg_out.data` = 0, `msg_out.empty` = 0
  - `zero_len_indi` = 0, `msg_done_indi` = 0
  - `cmd_rdy` = 1, `data_in_rdy` = 0.
- **Latency.** `data_in` accepted in cycle N appears on `msg_out` in cycle N+1.
- **Throughput.**
  - One word per cycle under `msg_out.rdy=1`.
  - One bubble cycle between messages: the command is accepted in `IDLE`, and the first data is accepted on the next cycle.
- **Stability.** While `msg_out.valid=1` and `msg_out.rdy=0`, all `msg_out` fields hold stable and `data_in_rdy=0`.
- **`rdy` transitions.** `msg_out.rdy` may toggle arbitrarily. A word is never dropped or duplicated.
- **Command timing.** A command presented in `IN_MSG` waits; `cmd_rdy` rises in the cycle after the last word is accepted.
- **Indicators.** `zero_len_indi` asserts in the cycle after command accept. `msg_done_indi` is registered and asserts in the cycle after the eop handshake.
- **Reset dominance.** `rst` overrides all inputs in the same edge.

## Configuration
- **`AVALON_PACKETIZER_ZERO_PAD_EN` defined:** pad bytes on the eop word are zeroed as described above.
- **Not defined:** `data` passes through unmodified on all words, including pad bytes. Framing, `empty`, and timing are identical in both cases.

## Test plan
All scenarios use W=4.
- **Two full words.** `cmd_len=8`, words `0x01020304`, `0x05060708`, `rdy=1` → two output beats: first `sop=1 eop=0 empty=0`, second `sop=0 eop=1 empty=0`; one `msg_done_indi` pulse.
- **Partial last word.** `cmd_len=5`, words `0x11223344`, `0xAABBCCDD` → second beat `eop=1 empty=3 data=0xAA000000` with `_ZERO_PAD_EN`, `0xAABBCCDD` without.
- **Single word.** `cmd_len=3`, word `0xDEADBEEF` → one beat `sop=1 eop=1 empty=1 data=0xDEADBE00`; `cmd_rdy` high again the next cycle.
- **Backpressure.** `cmd_len=12`; hold `rdy=0` for 3 cycles after the first beat → first beat held stable, `data_in_rdy=0` throughout; the remaining two beats follow in order once `rdy=1`.
- **Zero length.** `cmd_len=0`, then `cmd_len=4` → `zero_len_indi` pulses once with no output beat; the next message is emitted normally with `sop=1 eop=1`.
- **Reset mid-message.** Assert `rst` after 1 of 3 words → `msg_out.valid=0` next cycle, state `IDLE`; a new `cmd_len=4` message starts with `sop=1`, and no stray eop appears.
